// File: rtl/sim_frame_tracker.sv
// Frame accounting ahead of the sim dump controller: syncs vsync/led, counts frames, drives dump window and sim_done.
// Latency: vs fall -> frame_stb/frame_cnt after SYNC+1 edges; dump_en one cycle later; no backpressure (free-running strobes).
module sim_frame_tracker #(
    parameter int          WAIT_DL   = 1,
    parameter logic [31:0] MAXFRAMES = 32'd0,
    parameter int          SYNC      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        led,
    input  logic [31:0] cfg_start,
    input  logic [31:0] cfg_len,
    output logic [31:0] frame_cnt,
    output logic        frame_stb,
    output logic        dump_en,
    output logic        dump_start_stb,
    output logic        dump_stop_stb,
    output logic        sim_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [SYNC-1:0]   vs_sync_q;
    logic              vs_prev_q;
    logic [1:0]        led_sync_q;
    logic              led_prev_q;
    logic [31:0]       cfg_start_q;
    logic [31:0]       cfg_len_q;
    logic [31:0]       frame_cnt_q;
    logic              frame_stb_q;
    logic              dump_en_q;
    logic              dump_en_dly_q;
    logic              dump_start_stb_q;
    logic              dump_stop_stb_q;
    logic              sim_done_q;

    logic              vs_s_d;
    logic              vs_fall_d;
    logic              dl_done_d;
    logic [32:0]       win_sum_d;
    logic [31:0]       win_end_d;
    logic              in_win_d;
    logic              max_hit_d;

    // Synchronisers power up at 1 so a low input at reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_sync_q  <= '1;
            vs_prev_q  <= 1'b1;
            led_sync_q <= 2'b11;
            led_prev_q <= 1'b1;
        end else begin
            vs_sync_q  <= {vs_sync_q[SYNC-2:0], vs};
            vs_prev_q  <= vs_s_d;
            led_sync_q <= {led_sync_q[0], led};
            led_prev_q <= led_sync_q[1];
        end
    end

    assign vs_s_d    = vs_sync_q[SYNC-1];
    assign vs_fall_d = vs_prev_q & ~vs_s_d;
    assign dl_done_d = led_prev_q & ~led_sync_q[1];

    // An overflowing window end means the window runs to the top of the counter range.
    assign win_sum_d = {1'b0, cfg_start_q} + {1'b0, cfg_len_q};
    assign win_end_d = win_sum_d[32] ? 32'hFFFF_FFFF : win_sum_d[31:0];
    assign in_win_d  = (frame_cnt_q >= cfg_start_q) &&
                       ((cfg_len_q == 32'd0) || win_sum_d[32] || (frame_cnt_q < win_end_d));
    assign max_hit_d = (MAXFRAMES != 32'd0) && (frame_cnt_q == MAXFRAMES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cfg_start_q      <= 32'd0;
            cfg_len_q        <= 32'd0;
            frame_cnt_q      <= 32'd0;
            frame_stb_q      <= 1'b0;
            dump_en_q        <= 1'b0;
            dump_en_dly_q    <= 1'b0;
            dump_start_stb_q <= 1'b0;
            dump_stop_stb_q  <= 1'b0;
            sim_done_q       <= 1'b0;
        end else begin
            frame_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (WAIT_DL != 0) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q     <= S_COUNT;
                        cfg_start_q <= cfg_start;
                        cfg_len_q   <= cfg_len;
                    end
                end
                S_LOAD: begin
                    if (dl_done_d) begin
                        state_q     <= S_COUNT;
                        cfg_start_q <= cfg_start;
                        cfg_len_q   <= cfg_len;
                    end
                end
                S_COUNT: begin
                    if (max_hit_d) begin
                        state_q    <= S_DONE;
                        sim_done_q <= 1'b1;
                    end else if (vs_fall_d) begin
                        frame_stb_q <= 1'b1;
                        if (frame_cnt_q != 32'hFFFF_FFFF) begin
                            frame_cnt_q <= frame_cnt_q + 32'd1;
                        end
                    end
                end
                default: begin
                    sim_done_q <= 1'b1;
                end
            endcase

            dump_en_q        <= (state_q == S_COUNT) && in_win_d;
            dump_en_dly_q    <= dump_en_q;
            dump_start_stb_q <= dump_en_q & ~dump_en_dly_q;
            dump_stop_stb_q  <= ~dump_en_q & dump_en_dly_q;
        end
    end

    assign frame_cnt      = frame_cnt_q;
    assign frame_stb      = frame_stb_q;
    assign dump_en        = dump_en_q;
    assign dump_start_stb = dump_start_stb_q;
    assign dump_stop_stb  = dump_stop_stb_q;
    assign sim_done       = sim_done_q;

endmodule
